rv_switch_input_device: RTL
===========================

Name: rv_switch_input_device

Overview:
Memory-mapped input peripheral on the data memory bus: the read-side counterpart of the seven-segment output device. It samples board switches/keys through synchronizers and per-bit debouncers, and exposes the debounced level in a STATUS register. Rising edges are recorded in a sticky EDGE register that is cleared by a write-1-to-clear. The CPU polls both registers with ordinary loads and stores.

Parameters:
NUM_IN, 16, number of physical inputs (1..XLEN), mapped to bits [NUM_IN-1:0]
DEBOUNCE_CYCLES, 50000, consecutive cycles an input must differ from its stable value before it is accepted (1 ms at 50 MHz); >=1
SYNC_STAGES, 2, synchronizer flop depth; >=2

Ports:
clk_i  in  1  system clock, single clock domain
arstn_i  in  1  asynchronous active-low reset
data_rvalid_o  out  1  response valid (read data or write acknowledge), one-cycle pulse
data_rdata_o  out  XLEN  read data, valid when data_rvalid_o=1
data_req_i  in  1  bus request
data_we_i  in  1  1=write, 0=read
data_be_i  in  XLEN/8  byte enables (writes only)
data_addr_i  in  XLEN  byte address
data_wdata_i  in  XLEN  write data
sw_i  in  NUM_IN  raw asynchronous switch/key inputs

Behaviour:
- Reset: asynchronous, active-low. Clears synchronizers, debounce counters, stable levels, EDGE, data_rvalid_o and data_rdata_o to 0.
- Address decode: a request targets this device only when data_addr_i == ADDRESS_SW_STATUS or data_addr_i == ADDRESS_SW_EDGE.
- Other addresses: no response; data_rvalid_o stays 0.
- Synchronizer: each sw_i bit passes through SYNC_STAGES flops, giving sync[i].
- Debounce, per bit, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync==stable: counter <= 0.
  - sync!=stable and counter==DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Otherwise: counter <= counter+1.
  - Net effect: stable changes exactly DEBOUNCE_CYCLES cycles after sync first differs, provided sync holds the new value throughout. Any return to the old value restarts the count.
- Rise pulse: one-cycle rise[i]=1 in the cycle where stable is updated 0->1. Falling edges are not recorded.
- EDGE register, per bit:
  - Set by rise[i].
  - Cleared by a write to ADDRESS_SW_EDGE where wdata[i]=1 and the byte enable covering bit i is 1.
  - Set and clear in the same cycle: set wins.
  - Bits >= NUM_IN always read 0.
- STATUS register: read-only. Bits [NUM_IN-1:0] = stable, upper bits 0. Writes are acknowledged and have no effect.
- Read latency: 1 cycle.
  - A request at cycle N with data_req_i=1 and data_we_i=0 to a mapped address gives data_rvalid_o=1 at N+1.
  - data_rdata_o at N+1 = register value as it stood at cycle N (before any same-cycle update).
- Write acknowledge: a mapped write at cycle N gives data_rvalid_o=1 at N+1 with data_rdata_o=0.
- Idle/default: in any cycle without a mapped request, data_rvalid_o <= 0 and data_rdata_o <= 0.
- Back-to-back requests: accepted every cycle, no stall, each answered exactly once in the following cycle.

Decomposition:
- rv_pkg additions:
  - ADDRESS_SW_STATUS and ADDRESS_SW_EDGE (word-aligned, adjacent to ADDRESS_HEX).
  - DEBOUNCE_CYCLES_DEFAULT.
- Sub-module rv_input_debounce: one bit. Contains the synchronizer, counter and stable flop; outputs stable_o and rise_o. Parameters SYNC_STAGES and DEBOUNCE_CYCLES.
- Top level: generate loop of NUM_IN instances, plus the EDGE register, address decode and response flops.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, NUM_IN=16):
1. Reset, then read STATUS and EDGE -> data_rvalid_o=1 one cycle after each request, data_rdata_o=0x0; outside responses data_rvalid_o=0.
2. sw_i[3] 0->1 and held -> STATUS reads 0x0 before cycle 2+4 after the change, 0x8 from then on; EDGE reads 0x8. Re-run with sw_i[3] high for only 3 cycles -> STATUS and EDGE stay 0x0.
3. EDGE=0x8:
   - Write 0x8 with be=4'b0010 -> EDGE still 0x8.
   - Write 0x8 with be=4'b0001 -> EDGE reads 0x0, STATUS still 0x8.
4. Align a W1C write of bit 5 with the rise[5] cycle -> EDGE bit 5 reads 1.
5. Read of unmapped address ADDRESS_HEX -> data_rvalid_o stays 0. Three back-to-back reads STATUS, EDGE, STATUS -> three consecutive rvalid pulses with correct data. Write 0xFFFF to STATUS -> ack, STATUS unchanged.
6. arstn_i asserted for one cycle mid-debounce (counter=2) with sw_i[0]=1 -> all outputs 0 immediately; after release, STATUS bit 0 sets only after a full 2+4 cycles.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared bus width, memory map and switch-device types.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] ADDRESS_HEX       = 32'h0001_0000;
  localparam logic [XLEN-1:0] ADDRESS_SW_STATUS = 32'h0001_0004;
  localparam logic [XLEN-1:0] ADDRESS_SW_EDGE   = 32'h0001_0008;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int SYNC_STAGES_DEFAULT     = 2;

  typedef enum logic [1:0] {
    SW_SEL_NONE,
    SW_SEL_STATUS,
    SW_SEL_EDGE
  } sw_sel_e;

  function automatic sw_sel_e sw_decode(input logic [XLEN-1:0] addr);
    if (addr == ADDRESS_SW_STATUS) begin
      return SW_SEL_STATUS;
    end else if (addr == ADDRESS_SW_EDGE) begin
      return SW_SEL_EDGE;
    end
    return SW_SEL_NONE;
  endfunction

endpackage

// File: rtl/rv_input_debounce.sv
// rtl/rv_input_debounce.sv - one-bit synchronizer, debounce counter and stable level.
module rv_input_debounce
  import rv_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic d_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_bit;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], d_i};
    sync_bit = sync_q[SYNC_STAGES-1];
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_o   = 1'b0;
    // Any cycle agreeing with the stable level restarts the qualification window.
    if (sync_bit == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_bit;
      cnt_d    = '0;
      rise_o   = sync_bit;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/rv_switch_input_device.sv
// rtl/rv_switch_input_device.sv - memory-mapped debounced switch STATUS and sticky rising-EDGE registers.
module rv_switch_input_device
  import rv_pkg::*;
#(
  parameter int NUM_IN          = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  input  logic [NUM_IN-1:0] sw_i
);

  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] rise;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    rv_input_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .d_i     (sw_i[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i])
    );
  end

  logic [NUM_IN-1:0] edge_q, edge_d;
  logic [NUM_IN-1:0] clr_mask;
  logic              rvalid_q, rvalid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  sw_sel_e           sel;

  always_comb begin
    sel      = data_req_i ? sw_decode(data_addr_i) : SW_SEL_NONE;
    clr_mask = '0;
    if (sel == SW_SEL_EDGE && data_we_i) begin
      for (int i = 0; i < NUM_IN; i++) begin
        clr_mask[i] = data_wdata_i[i] & data_be_i[i/8];
      end
    end
    // A rise landing in the same cycle as its clear must not be lost.
    edge_d = (edge_q & ~clr_mask) | rise;

    rvalid_d = (sel != SW_SEL_NONE);
    rdata_d  = '0;
    if (!data_we_i) begin
      case (sel)
        SW_SEL_STATUS: rdata_d = XLEN'(stable);
        SW_SEL_EDGE:   rdata_d = XLEN'(edge_q);
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      edge_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      edge_q   <= edge_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{data_wdata_i, data_be_i};

endmodule
